instr_sequencer: RTL

- Front end of the 8-bit CPU: fetches instructions from the instruction memory and drives the Control_Unit's Opcode/En inputs.
- Holds the program counter (PC) and instruction register (IR).
- Fetches over a request/valid handshake and handles HLT and JMP internally.
- Issues every other opcode to the Control_Unit with a single-cycle En pulse, then waits out a fixed execute window.

---
 rtl/instr_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: front end of the 8-bit CPU.
// Fetches instruction words over a request/valid handshake, owns the PC and
// IR, executes HLT and JMP internally and issues every other opcode to the
// Control_Unit with a one-cycle En strobe followed by a fixed execute window.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous, active-high reset
//   Run          start/resume request (sampled in IDLE and HALT)
//   Halt_req     stop request, honoured at the next instruction boundary
//   Instr_rd     fetch request (high throughout FETCH)
//   Instr_addr   fetch address (always the PC)
//   Instr_data   instruction word: [7:5] opcode, [4:0] operand
//   Instr_valid  Instr_data valid this cycle
//   Opcode       registered opcode of the last issued instruction
//   Operand      registered operand of the last issued instruction
//   En           one-cycle issue strobe
//   Busy         high in FETCH, DECODE and EXEC
//   Halted       high in HALT
//   Pc           current PC (debug)
module instr_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Halt_req,
  output logic              Instr_rd,
  output logic [ADDR_W-1:0] Instr_addr,
  input  logic [7:0]        Instr_data,
  input  logic              Instr_valid,
  output logic [2:0]        Opcode,
  output logic [ADDR_W-1:0] Operand,
  output logic              En,
  output logic              Busy,
  output logic              Halted,
  output logic [ADDR_W-1:0] Pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [3:0]        exec_cnt;
  logic              halt_pend;

  always_comb begin
    Busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    Halted = (state == S_HALT);
  end

  assign Instr_rd   = (state == S_FETCH);
  assign Instr_addr = pc;
  assign Pc         = pc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      Opcode    <= '0;
      Operand   <= '0;
      En        <= 1'b0;
      exec_cnt  <= '0;
      halt_pend <= 1'b0;
    end else begin
      // En is a strobe: only the DECODE issue path raises it, for one cycle.
      En <= 1'b0;

      if (Halt_req && Busy) begin
        halt_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (Run) begin
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (Instr_valid) begin
            ir    <= Instr_data;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (ir[7:5])
            OP_HLT: begin
              pc    <= pc + 1'b1;
              state <= S_HALT;
            end
            OP_JMP: begin
              pc    <= ADDR_W'(ir[4:0]);
              state <= halt_pend ? S_HALT : S_FETCH;
            end
            default: begin
              Opcode   <= ir[7:5];
              Operand  <= ADDR_W'(ir[4:0]);
              En       <= 1'b1;
              exec_cnt <= '0;
              state    <= S_EXEC;
            end
          endcase
        end

        S_EXEC: begin
          // A pending halt is only acted on once the full window has elapsed.
          if (exec_cnt == EXEC_LAST) begin
            pc    <= pc + 1'b1;
            state <= halt_pend ? S_HALT : S_FETCH;
          end else begin
            exec_cnt <= exec_cnt + 1'b1;
          end
        end

        S_HALT: begin
          if (Run) begin
            halt_pend <= 1'b0;
            state     <= S_FETCH;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
